sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Single-owner scheduler for the board's synchronous SSRAM. It shares the memory between a write requester (camera store path) and a read requester (display fetch path).
- Reads have priority because the display must not underflow. A streak counter bounds write starvation, and a turnaround cycle is inserted before any write that follows a read.
- Sits between the FIFO-side datapath and the SRAM pins. It owns address, data-drive, WE/OE and ADSC/ADSP generation.

Parameters:
ADDR_W, 19, SRAM word address width
DATA_W, 32, SRAM data width
READ_LAT, 2, cycles from read issue (ADSP low) until data is valid on SRAM_DATA_IN; legal range 1..4
MAX_RD_STREAK, 4, consecutive read grants allowed while a write is pending

Ports:
CLK  in  1  system clock; SRAM clocked on same edge
RESET_N  in  1  asynchronous, active-low reset
WR_REQ  in  1  write request, level; held until acked
WR_ADDR  in  ADDR_W  write address
WR_DATA  in  DATA_W  write data
WR_ACK  out  1  one-cycle pulse; WR_ADDR/WR_DATA consumed this cycle
RD_REQ  in  1  read request, level; held until acked
RD_ADDR  in  ADDR_W  read address
RD_ACK  out  1  one-cycle pulse; RD_ADDR consumed this cycle
RD_DATA  out  DATA_W  read data, registered
RD_VALID  out  1  one-cycle pulse; RD_DATA valid
SRAM_ADDRESS  out  ADDR_W  registered address
SRAM_DATA_OUT  out  DATA_W  registered write data
SRAM_DATA_OE  out  1  1 = drive bus with SRAM_DATA_OUT (top level builds the tri-state)
SRAM_DATA_IN  in  DATA_W  bus sampled for reads
SRAM_WE_N  out  1  write strobe, active low
SRAM_OE_N  out  1  output enable, active low
SRAM_ADSC_N  out  1  controller address strobe, low on write issue
SRAM_ADSP_N  out  1  processor address strobe, low on read issue

Behaviour:
- Reset (async, any state): state=IDLE, streak=0. WR_ACK=0, RD_ACK=0, RD_VALID=0, RD_DATA=0. SRAM_WE_N, SRAM_OE_N, SRAM_ADSC_N and SRAM_ADSP_N all =1. SRAM_DATA_OE=0, SRAM_ADDRESS=0, SRAM_DATA_OUT=0. An in-flight read is discarded with no RD_VALID.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, TURN.
- Grant decision is made in IDLE only. ACK is combinational, asserted in the IDLE cycle that grants. Address/data are latched on that edge.
  - Grant read if RD_REQ && !(WR_REQ && streak==MAX_RD_STREAK).
  - Otherwise grant write if WR_REQ.
  - Both requests low: stay in IDLE, all strobes inactive.
- Write path:
  - Grant edge: IDLE -> WR_ISSUE, or IDLE -> TURN if the previous state was RD_WAIT.
  - TURN lasts 1 cycle, all strobes inactive, DATA_OE=0, then -> WR_ISSUE.
  - WR_ISSUE lasts 1 cycle: ADSC_N=0, WE_N=0, DATA_OE=1, address and data from the latches. Then -> IDLE.
  - Write throughput: 2 cycles per write (3 with turnaround).
- Read path:
  - RD_ISSUE (cycle k): ADSP_N=0, address from latch, DATA_OE=0.
  - RD_WAIT covers cycles k+1..k+READ_LAT with OE_N=0.
  - SRAM_DATA_IN is sampled into RD_DATA at the end of cycle k+READ_LAT. RD_VALID=1 in cycle k+READ_LAT+1, which is also an IDLE cycle.
  - Read throughput: READ_LAT+2 cycles per read.
- Streak counter:
  - Increments on a read grant while WR_REQ=1, saturating at MAX_RD_STREAK.
  - Clears on a write grant, or in any IDLE cycle with WR_REQ=0.
- Bus safety: DATA_OE and OE_N=0 are never asserted in the same cycle. DATA_OE is never 1 in the cycle right after OE_N=0.
- Requests dropped before ACK are ignored. ACK is never issued outside IDLE.
- Only SRAM_ADSC_N, SRAM_ADSP_N and SRAM_WE_N are allowed as combinational decodes of the state register. All other SRAM-side outputs are registered.

Test Plan:
- Reset check: assert RESET_N=0 mid-RD_WAIT (READ_LAT=2) -> all strobes high, DATA_OE=0 the same cycle; no RD_VALID after release; first post-reset grant occurs in IDLE.
- Single write: WR_REQ=1, WR_ADDR=0x12345, WR_DATA=0xDEADBEEF, idle history -> WR_ACK in cycle 0; cycle 1 has ADSC_N=0, WE_N=0, DATA_OE=1, SRAM_ADDRESS=0x12345, SRAM_DATA_OUT=0xDEADBEEF.
- Single read: RD_ADDR=0x00100 granted at cycle 0, SRAM model returns 0xA5A5A5A5 at cycle 3 -> RD_VALID=1 with RD_DATA=0xA5A5A5A5 in cycle 4.
- Turnaround: a read immediately followed by a pending write -> exactly one TURN cycle (all strobes high, DATA_OE=0) before WR_ISSUE.
- Starvation: RD_REQ and WR_REQ held high -> grant order R,R,R,R,W,R,R,R,R,W; WR_ACK never more than 4 reads apart.
- Both requests low for 100 cycles -> no ACKs, all strobes high, DATA_OE=0, streak=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: single-owner scheduler for the synchronous SSRAM.
// Read requests win by default so the display never underflows. A streak
// counter bounds how long a pending write can be starved. A turnaround cycle
// is placed between a read and a directly following write so the SRAM output
// drivers are off before the controller drives the bus.
module sram_port_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 32,
  parameter int READ_LAT      = 2,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_ACK,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_ACK,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  output logic [DATA_W-1:0] SRAM_DATA_OUT,
  output logic              SRAM_DATA_OE,
  input  logic [DATA_W-1:0] SRAM_DATA_IN,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_ADSC_N,
  output logic              SRAM_ADSP_N
);

  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam int CNT_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    TURN
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;
  logic                prevRdWait_q;
  logic                grantRd, grantWr, rdLast;

  logic [ADDR_W-1:0]   sramAddress_q;
  logic [DATA_W-1:0]   sramDataOut_q;
  logic                dataOe_q;
  logic                oeN_q;
  logic [DATA_W-1:0]   rdData_q;
  logic                rdValid_q;

  // Next-state, grant arbitration and streak bookkeeping.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    waitCnt_d = waitCnt_q;
    grantRd   = 1'b0;
    grantWr   = 1'b0;
    rdLast    = 1'b0;
    case (state_q)
      IDLE: begin
        if (RD_REQ && !(WR_REQ && streak_q == STREAK_W'(MAX_RD_STREAK))) begin
          grantRd = 1'b1;
          state_d = RD_ISSUE;
          if (WR_REQ && streak_q != STREAK_W'(MAX_RD_STREAK)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (WR_REQ) begin
          grantWr  = 1'b1;
          streak_d = '0;
          state_d  = prevRdWait_q ? TURN : WR_ISSUE;
        end
        if (!WR_REQ) begin
          streak_d = '0;
        end
      end
      TURN:     state_d = WR_ISSUE;
      WR_ISSUE: state_d = IDLE;
      RD_ISSUE: begin
        state_d   = RD_WAIT;
        waitCnt_d = '0;
      end
      RD_WAIT: begin
        if (waitCnt_q == CNT_W'(READ_LAT - 1)) begin
          rdLast  = 1'b1;
          state_d = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, streak/latency counters and the read-to-write history bit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      waitCnt_q    <= '0;
      prevRdWait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      waitCnt_q    <= waitCnt_d;
      prevRdWait_q <= (state_q == RD_WAIT);
    end
  end

  // Registered SRAM pins and read-return path, all derived from the next state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sramAddress_q <= '0;
      sramDataOut_q <= '0;
      dataOe_q      <= 1'b0;
      oeN_q         <= 1'b1;
      rdData_q      <= '0;
      rdValid_q     <= 1'b0;
    end else begin
      if (grantRd) begin
        sramAddress_q <= RD_ADDR;
      end else if (grantWr) begin
        sramAddress_q <= WR_ADDR;
        sramDataOut_q <= WR_DATA;
      end
      dataOe_q  <= (state_d == WR_ISSUE);
      oeN_q     <= (state_d != RD_WAIT);
      rdValid_q <= rdLast;
      if (rdLast) begin
        rdData_q <= SRAM_DATA_IN;
      end
    end
  end

  assign WR_ACK        = grantWr;
  assign RD_ACK        = grantRd;
  assign RD_DATA       = rdData_q;
  assign RD_VALID      = rdValid_q;
  assign SRAM_ADDRESS  = sramAddress_q;
  assign SRAM_DATA_OUT = sramDataOut_q;
  assign SRAM_DATA_OE  = dataOe_q;
  assign SRAM_OE_N     = oeN_q;
  assign SRAM_ADSC_N   = (state_q != WR_ISSUE);
  assign SRAM_WE_N     = (state_q != WR_ISSUE);
  assign SRAM_ADSP_N   = (state_q != RD_ISSUE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter with a small latency-accurate SSRAM read model.
module tb_sram_port_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;

  logic              clk = 1'b0;
  logic              resetN;
  logic              wrReq, rdReq;
  logic [ADDR_W-1:0] wrAddr, rdAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrAck, rdAck, rdValid;
  logic [DATA_W-1:0] rdData;
  logic [ADDR_W-1:0] sramAddress;
  logic [DATA_W-1:0] sramDataOut, sramDataIn;
  logic              sramDataOe, sramWeN, sramOeN, sramAdscN, sramAdspN;

  int checks   = 0;
  int failures = 0;

  int                mdlCnt = 0;
  logic [ADDR_W-1:0] mdlAddr = '0;

  int                grants, drain, rdCount, seenWr;
  logic [11:0]       seq;
  logic              prevOeN, gotRd, gotWr;
  logic [ADDR_W-1:0] addrQ[$];

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .MAX_RD_STREAK(4)
  ) dut (
    .CLK(clk), .RESET_N(resetN),
    .WR_REQ(wrReq), .WR_ADDR(wrAddr), .WR_DATA(wrData), .WR_ACK(wrAck),
    .RD_REQ(rdReq), .RD_ADDR(rdAddr), .RD_ACK(rdAck),
    .RD_DATA(rdData), .RD_VALID(rdValid),
    .SRAM_ADDRESS(sramAddress), .SRAM_DATA_OUT(sramDataOut),
    .SRAM_DATA_OE(sramDataOe), .SRAM_DATA_IN(sramDataIn),
    .SRAM_WE_N(sramWeN), .SRAM_OE_N(sramOeN),
    .SRAM_ADSC_N(sramAdscN), .SRAM_ADSP_N(sramAdspN)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] sramData(input logic [ADDR_W-1:0] a);
    return (a == 19'h00100) ? 32'hA5A5A5A5 : {13'h1A2B, a};
  endfunction

  // SSRAM read model: data is valid only during cycle k+READ_LAT after ADSP_N low in cycle k.
  always @(negedge clk) begin
    if (mdlCnt != 0) begin
      mdlCnt = mdlCnt - 1;
      sramDataIn = (mdlCnt == 0) ? sramData(mdlAddr) : 32'hBAD0BAD0;
    end else begin
      sramDataIn = 32'hBAD0BAD0;
    end
    if (!sramAdspN) begin
      mdlCnt  = READ_LAT;
      mdlAddr = sramAddress;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wReq, input logic [ADDR_W-1:0] wAddr,
                               input logic [DATA_W-1:0] wData, input logic rReq,
                               input logic [ADDR_W-1:0] rAddr);
    wrReq  = wReq;
    wrAddr = wAddr;
    wrData = wData;
    rdReq  = rReq;
    rdAddr = rAddr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    sramDataIn = '0;

    // Reset state
    @(negedge clk);
    checkOutput("rstStrobes", {sramAdscN, sramAdspN, sramWeN, sramOeN}, 4'hF);
    checkOutput("rstFlags", {sramDataOe, wrAck, rdAck, rdValid}, 4'h0);
    checkOutput("rstAddr", sramAddress, 0);
    checkOutput("rstRdData", rdData, 0);
    nextCycle();
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("idleAck", {wrAck, rdAck}, 2'b00);
    nextCycle();

    // Single write
    applyStimulus(1'b1, 19'h12345, 32'hDEADBEEF, 1'b0, '0);
    @(negedge clk);
    checkOutput("wrAck", {wrAck, rdAck}, 2'b10);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("wrIssueStrobes", {sramAdscN, sramWeN, sramAdspN, sramOeN, sramDataOe}, 5'b00111);
    checkOutput("wrIssueAddr", sramAddress, 19'h12345);
    checkOutput("wrIssueData", sramDataOut, 32'hDEADBEEF);
    checkOutput("wrIssueNoAck", wrAck, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("wrDone", {sramAdscN, sramWeN, sramDataOe}, 3'b110);
    nextCycle();

    // Single read
    applyStimulus(1'b0, '0, '0, 1'b1, 19'h00100);
    @(negedge clk);
    checkOutput("rdAck", {wrAck, rdAck}, 2'b01);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("rdIssue", {sramAdspN, sramOeN, sramDataOe, sramAdscN}, 4'b0101);
    checkOutput("rdIssueAddr", sramAddress, 19'h00100);
    nextCycle();
    @(negedge clk);
    checkOutput("rdWait1", {sramAdspN, sramOeN, sramDataOe}, 3'b100);
    nextCycle();
    @(negedge clk);
    checkOutput("rdWait2", {sramOeN, rdValid}, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("rdValid", {rdValid, sramOeN}, 2'b11);
    checkOutput("rdData", rdData, 32'hA5A5A5A5);
    nextCycle();
    @(negedge clk);
    checkOutput("rdValidPulse", rdValid, 0);
    nextCycle();

    // Turnaround: write pending right behind a read
    applyStimulus(1'b0, '0, '0, 1'b1, 19'h00200);
    @(negedge clk);
    checkOutput("taRdAck", rdAck, 1);
    nextCycle();
    applyStimulus(1'b1, 19'h0ABCD, 32'h12345678, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("taNoAckBusy", {wrAck, rdAck}, 2'b00);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("taWrAck", {wrAck, rdValid}, 2'b11);
    checkOutput("taRdData", rdData, sramData(19'h00200));
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("taTurn", {sramAdscN, sramAdspN, sramWeN, sramOeN, sramDataOe}, 5'b11110);
    nextCycle();
    @(negedge clk);
    checkOutput("taWrIssue", {sramAdscN, sramWeN, sramDataOe}, 3'b001);
    checkOutput("taWrAddr", sramAddress, 19'h0ABCD);
    nextCycle();

    // Starvation bound: both requests held, 12 grants then drain
    applyStimulus(1'b1, 19'h40000, 32'h11110000, 1'b1, 19'h01000);
    grants  = 0;
    drain   = 0;
    seq     = '0;
    prevOeN = 1'b1;
    for (int cyc = 0; cyc < 150 && drain < 10; cyc++) begin
      @(negedge clk);
      checkOutput("busOverlap", sramDataOe & ~sramOeN, 0);
      checkOutput("busAfterOe", sramDataOe & ~prevOeN, 0);
      checkOutput("dualAck", wrAck & rdAck, 0);
      prevOeN = sramOeN;
      if (rdValid) begin
        if (addrQ.size() == 0) checkOutput("spuriousValid", 1, 0);
        else checkOutput("stRdData", rdData, sramData(addrQ.pop_front()));
      end
      gotRd = rdAck;
      gotWr = wrAck;
      if (grants < 12 && (gotRd || gotWr)) begin
        seq = {seq[10:0], gotWr};
        grants++;
      end
      if (gotRd) addrQ.push_back(rdAddr);
      nextCycle();
      if (grants >= 12) begin
        wrReq = 1'b0;
        rdReq = 1'b0;
        drain++;
      end else begin
        if (gotRd) rdAddr = rdAddr + 1'b1;
        if (gotWr) begin
          wrAddr = wrAddr + 1'b1;
          wrData = wrData + 32'h1;
        end
      end
    end
    checkOutput("grantCount", grants, 12);
    checkOutput("grantOrder", seq, 12'b000010000100);
    checkOutput("rdDrained", addrQ.size(), 0);

    // Quiet bus for 100 cycles
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("quiet", {wrAck, rdAck, rdValid, sramDataOe,
                            sramAdscN, sramAdspN, sramWeN, sramOeN}, 8'b0000_1111);
      nextCycle();
    end

    // Streak was left at 2 before the quiet period; it must restart at 0
    applyStimulus(1'b1, 19'h50000, 32'h22220000, 1'b1, 19'h02000);
    rdCount = 0;
    seenWr  = 0;
    for (int cyc = 0; cyc < 60 && seenWr == 0; cyc++) begin
      @(negedge clk);
      gotRd = rdAck;
      if (rdAck) rdCount++;
      if (wrAck) seenWr = 1;
      nextCycle();
      if (gotRd) rdAddr = rdAddr + 1'b1;
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("streakWrSeen", seenWr, 1);
    checkOutput("streakReads", rdCount, 4);
    repeat (10) nextCycle();

    // Reset asserted in the middle of RD_WAIT
    applyStimulus(1'b0, '0, '0, 1'b1, 19'h00300);
    @(negedge clk);
    checkOutput("rstRdAck", rdAck, 1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    nextCycle();
    checkOutput("inRdWait", sramOeN, 0);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("rstMidStrobes", {sramAdscN, sramAdspN, sramWeN, sramOeN, sramDataOe}, 5'b11110);
    nextCycle();
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rstNoValid", rdValid, 0);
      nextCycle();
    end
    applyStimulus(1'b1, 19'h55555, 32'hCAFEF00D, 1'b0, '0);
    @(negedge clk);
    checkOutput("postRstWrAck", wrAck, 1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("postRstWrIssue", {sramAdscN, sramWeN, sramDataOe}, 3'b001);
    checkOutput("postRstWrData", sramDataOut, 32'hCAFEF00D);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
